// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit multiplexed common-anode seven-segment driver with frame-coherent digit capture.
// Optional feature macro: LEADING_ZERO_BLANK_EN (dark the slots above the most significant nonzero digit).
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       AN_DARK  = 4'b1111;
  localparam logic [6:0]       SEG_DARK = 7'h7F;

  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic             w_tick;
  logic [3:0]       w_digit;
  logic [3:0]       w_blank;
  logic             w_dark;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // A tick only exists while enabled, so dropping enable on the wrap edge swallows it.
  assign w_tick = enable && (r_presc == LAST_CNT);

  // Slot-time prescaler, frozen while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else if (enable) begin
      r_presc <= r_presc + CNT_ONE;
    end else begin
      r_presc <= r_presc;
    end
  end

  // Slot index and shadow digits; the shadow only reloads on the 3->0 wrap so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx    <= 2'd0;
      r_shadow <= 16'h0000;
    end else if (w_tick) begin
      r_idx <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_shadow <= {thousands, hundreds, tens, ones};
      end else begin
        r_shadow <= r_shadow;
      end
    end else begin
      r_idx    <= r_idx;
      r_shadow <= r_shadow;
    end
  end

  // Digit of the current slot.
  always_comb begin
    w_digit = 4'h0;
    case (r_idx)
      2'd0:    w_digit = r_shadow[3:0];
      2'd1:    w_digit = r_shadow[7:4];
      2'd2:    w_digit = r_shadow[11:8];
      2'd3:    w_digit = r_shadow[15:12];
      default: w_digit = 4'h0;
    endcase
  end

  // Leading-zero mask, derived from the shadow so it only moves at frame capture.
  always_comb begin
    w_blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    w_blank[3] = (r_shadow[15:12] == 4'h0);
    w_blank[2] = w_blank[3] && (r_shadow[11:8] == 4'h0);
    w_blank[1] = w_blank[2] && (r_shadow[7:4] == 4'h0);
    w_blank[0] = 1'b0;
`else
    w_blank = 4'b0000;
`endif
    w_dark = !enable || w_blank[r_idx];
  end

  // Anode and cathode registers are loaded together so a lit anode never pairs with a stale segment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= AN_DARK;
      r_seg <= SEG_DARK;
    end else if (w_dark) begin
      r_an  <= AN_DARK;
      r_seg <= SEG_DARK;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= hex_to_seg(w_digit);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: literal vector tables plus a randomized run against a slot-time arithmetic model.
module tb_seven_seg_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] ones, tens, hundreds, thousands;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  // Model: count of enabled edges since reset, plus the displayed digit set.
  int         m_n;
  logic [3:0] m_sh [4];
  logic [3:0] m_an;
  logic [6:0] m_seg;

  typedef struct packed {
    logic [15:0] digits;  // {thousands,hundreds,tens,ones}
    logic [27:0] segs;    // {slot3,slot2,slot1,slot0}
  } vec_t;

  vec_t vecs [5];
  logic [3:0] f2_an  [4];
  logic [6:0] f2_seg [4];

  always #5 clk = ~clk;

  seven_seg_scan #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .an(an), .seg(seg), .dp(dp)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[d];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    for (int k = 0; k < 4; k++) m_sh[k] = 4'h0;
    m_an  = 4'b1111;
    m_seg = 7'h7F;
  endtask

  task automatic model_edge();
    int slot;
    int msd;
    bit blank;
    if (reset) begin
      model_reset();
    end else if (!enable) begin
      m_an  = 4'b1111;
      m_seg = 7'h7F;
    end else begin
      slot = (m_n / DIV) % 4;
      msd  = 0;
      for (int k = 0; k < 4; k++) if (m_sh[k] != 4'h0) msd = k;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (slot > msd);
`endif
      if (blank) begin
        m_an  = 4'b1111;
        m_seg = 7'h7F;
      end else begin
        m_an  = 4'b1111;
        m_an[slot] = 1'b0;
        m_seg = ref_seg(m_sh[slot]);
      end
      if ((m_n + 1) % FRAME == 0) begin
        m_sh[0] = ones; m_sh[1] = tens; m_sh[2] = hundreds; m_sh[3] = thousands;
      end
      m_n = (m_n + 1) % FRAME;
    end
  endtask

  task automatic step();
    logic ok;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_an", an, m_an);
    chk("model_seg", seg, m_seg);
    chk("dp", dp, 1'b1);
    ok = (an == 4'b1111) || ($countones(~an) == 1);
    chk("an_onehot_low", ok, 1'b1);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] ea, input logic [6:0] es);
    chk({nm, "_an"}, an, ea);
    chk({nm, "_seg"}, seg, es);
  endtask

  task automatic set_digits(input logic [15:0] d);
    {thousands, hundreds, tens, ones} = d;
  endtask

  task automatic pulse_reset();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    expect_out("async_reset", 4'b1111, 7'h7F);
    chk("async_reset_dp", dp, 1'b1);
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    int slot;

    vecs[0] = '{16'hFEDC, {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110}};
    vecs[1] = '{16'hBA98, {7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000}};
    vecs[2] = '{16'h7654, {7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001}};
    vecs[3] = '{16'h3210, {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}};
    vecs[4] = '{16'h8000, {7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    f2_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    f2_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    reset = 1'b1; enable = 1'b0;
    set_digits(16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_state", 4'b1111, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    reset = 1'b0;

    // Reset pulse in the middle of a slot, then restart from slot 0.
    enable = 1'b1;
    step(); step();
    pulse_reset();

    // First frame shows the reset shadow; second shows 1/2/3/4.
    set_digits(16'h1234);
    for (int i = 0; i < FRAME; i++) begin
      step();
      slot = i / DIV;
      ea = ~(4'b0001 << slot);
      es = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot != 0) begin ea = 4'b1111; es = 7'h7F; end
`endif
      expect_out("frame1", ea, es);
    end
    for (int i = 0; i < FRAME; i++) begin
      step();
      expect_out("frame2", f2_an[i / DIV], f2_seg[i / DIV]);
    end

    // Mid-frame input change is invisible until the wrap.
    for (int i = 0; i < FRAME; i++) begin
      step();
      expect_out("midframe_hold", f2_an[i / DIV], f2_seg[i / DIV]);
      if (i == 5) ones = 4'hF;
    end
    for (int i = 0; i < FRAME; i++) begin
      step();
      es = (i / DIV == 0) ? 7'b0001110 : f2_seg[i / DIV];
      expect_out("after_wrap", f2_an[i / DIV], es);
    end

    // Decode table: load one frame, check the following frame.
    for (int v = 0; v < 5; v++) begin
      set_digits(vecs[v].digits);
      for (int i = 0; i < FRAME; i++) step();
      for (int i = 0; i < FRAME; i++) begin
        step();
        slot = i / DIV;
        ea = ~(4'b0001 << slot);
        es = vecs[v].segs[slot*7 +: 7];
        expect_out("vec", ea, es);
      end
    end

    // Enable dropped during slot 2 for 10 cycles, shadow is 8/0/0/0.
    repeat (9) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out("disabled", 4'b1111, 7'h7F);
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("resume_slot2", 4'b1011, 7'b1000000);
    end
    step();
    expect_out("resume_slot3", 4'b0111, 7'b0000000);

    // Enable dropped exactly on a tick edge: the tick is swallowed.
    while (m_n % DIV != DIV - 1) step();
    ea = an;
    enable = 1'b0;
    step();
    expect_out("tick_drop", 4'b1111, 7'h7F);
    enable = 1'b1;
    step();
    chk("tick_drop_same_slot", an, ea);

    // Leading-zero case 0/0/0/7.
    while (m_n != 0) step();
    set_digits(16'h0007);
    for (int i = 0; i < FRAME; i++) step();
    for (int i = 0; i < FRAME; i++) begin
      step();
      slot = i / DIV;
      if (slot == 0) begin
        expect_out("lz_slot0", 4'b1110, 7'b1111000);
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        expect_out("lz_blank", 4'b1111, 7'h7F);
`else
        ea = ~(4'b0001 << slot);
        expect_out("lz_zero", ea, 7'b1000000);
`endif
      end
    end

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      enable = (r >= 12);
      if ($urandom_range(0, 4) == 0) set_digits(16'($urandom));
      if (r < 2) pulse_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
